// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   Serial boot loader for the instruction memory. Receives frames of the form
//   START, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, 4*CNT data bytes (big-endian words),
//   CSUM (XOR of every byte after START). It writes each word into imem, answers
//   ACK/NAK on the transmit handshake, stalls the CPU while a frame is in progress,
//   and pulses cpu_reset for one cycle after a good load.
//
//   Optional feature macro: LOADER_TIMEOUT_EN. When defined, an inter-byte timeout
//   aborts the frame with NAK after TIMEOUT_CYCLES cycles without an accepted byte.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   rx_data/valid/ready byte stream from the UART receiver
//   tx_data/valid/ready response byte to the UART transmitter
//   imem_we/addr/din    instruction memory write port (word addressed)
//   cpu_stall           high while a frame is being handled
//   cpu_reset           one-cycle restart pulse after an ACKed frame
module uart_imem_loader #(
  parameter int unsigned ADDR_W         = 12,
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              cpu_stall,
  output logic              cpu_reset
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
    S_DATA, S_CSUM, S_RESP, S_RESTART
  } state_t;

  state_t      state, stateNxt;
  logic        accept;
  logic [7:0]  addrHi, cntHi, csum;
  logic [15:0] wordsLeft;
  logic [1:0]  byteIdx;
  logic [23:0] shiftReg;
  logic        lastWord;   // final word's imem write is in flight this cycle
  logic        csumByte;   // the byte being accepted is the checksum
  logic        respAck;    // pending response is ACK
  logic        inFrame;
  logic        timeout;

  assign accept    = rx_valid && rx_ready;
  assign rx_ready  = (state != S_RESP) && (state != S_RESTART);
  assign tx_valid  = (state == S_RESP);
  assign cpu_stall = (state != S_IDLE);
  assign cpu_reset = (state == S_RESTART);
  assign inFrame   = (state >= S_ADDR_HI) && (state <= S_CSUM);

  // The last word is written while still in DATA so imem_we never leaks into
  // CSUM; a checksum byte arriving in that same cycle is taken directly.
  assign csumByte = accept && ((state == S_CSUM) || ((state == S_DATA) && lastWord));

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] toCnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                toCnt <= '0;
    else if (accept || !inFrame) toCnt <= '0;
    else                         toCnt <= toCnt + 32'd1;
  end

  assign timeout = inFrame && !accept && (toCnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      S_IDLE:    if (accept && rx_data == START_BYTE) stateNxt = S_ADDR_HI;
      S_ADDR_HI: if (accept) stateNxt = S_ADDR_LO;
      S_ADDR_LO: if (accept) stateNxt = S_CNT_HI;
      S_CNT_HI:  if (accept) stateNxt = S_CNT_LO;
      S_CNT_LO:  if (accept) stateNxt = ({cntHi, rx_data} == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:    if (csumByte) stateNxt = S_RESP;
                 else if (lastWord) stateNxt = S_CSUM;
      S_CSUM:    if (accept) stateNxt = S_RESP;
      S_RESP:    if (tx_ready) stateNxt = respAck ? S_RESTART : S_IDLE;
      S_RESTART: stateNxt = S_IDLE;
      default:   stateNxt = S_IDLE;
    endcase
    if (timeout) stateNxt = S_RESP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addrHi    <= '0;
      cntHi     <= '0;
      csum      <= '0;
      wordsLeft <= '0;
      byteIdx   <= '0;
      shiftReg  <= '0;
      lastWord  <= 1'b0;
      respAck   <= 1'b0;
      tx_data   <= '0;
      imem_we   <= '0;
      imem_addr <= '0;
      imem_din  <= '0;
    end else begin
      imem_we  <= 4'h0;
      lastWord <= 1'b0;
      // Post-increment once the write pulse has been presented.
      if (imem_we != 4'h0) imem_addr <= imem_addr + ADDR_W'(1);

      if (state == S_IDLE) begin
        csum    <= '0;
        byteIdx <= '0;
      end

      if (accept && inFrame && !csumByte) csum <= csum ^ rx_data;

      if (accept) begin
        unique case (state)
          S_ADDR_HI: addrHi <= rx_data;
          S_ADDR_LO: imem_addr <= ADDR_W'({addrHi, rx_data});
          S_CNT_HI:  cntHi <= rx_data;
          S_CNT_LO: begin
            wordsLeft <= {cntHi, rx_data};
            byteIdx   <= '0;
          end
          S_DATA: if (!lastWord) begin
            shiftReg <= {shiftReg[15:0], rx_data};
            byteIdx  <= byteIdx + 2'd1;
            if (byteIdx == 2'd3) begin
              imem_we   <= 4'hF;
              imem_din  <= {shiftReg, rx_data};
              wordsLeft <= wordsLeft - 16'd1;
              lastWord  <= (wordsLeft == 16'd1);
            end
          end
          default: ;
        endcase
      end

      if (csumByte) begin
        respAck <= (csum == rx_data);
        tx_data <= (csum == rx_data) ? ACK_BYTE : NAK_BYTE;
      end

      // Abort: a partial word is simply dropped since writes only fire on a 4th byte.
      if (timeout) begin
        respAck <= 1'b0;
        tx_data <= NAK_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_din;
  logic        cpu_stall;
  logic        cpu_reset;

  uart_imem_loader dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
    .cpu_stall(cpu_stall), .cpu_reset(cpu_reset)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;
  int cpuResetCnt = 0;
  logic [43:0] expW[$];   // {addr, data}
  logic [7:0]  expTx[$];

  typedef struct packed {
    logic [15:0]      addr;
    logic [15:0]      cnt;
    logic [3:0][31:0] words;
    logic             badCs;
    logic             expAck;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every write and every response transfer is popped and checked.
  always @(negedge clk) begin
    if (reset_n) begin
      if (imem_we != 4'h0) begin
        chk("imem_we_mask", {28'd0, imem_we}, 32'hF);
        if (expW.size() == 0) begin
          nCmp++; nErr++;
          $display("FAIL unexpected_write: got addr %h data %h want none", imem_addr, imem_din);
        end else begin
          logic [43:0] e;
          e = expW.pop_front();
          chk("imem_addr", {20'd0, imem_addr}, {20'd0, e[43:32]});
          chk("imem_din", imem_din, e[31:0]);
        end
      end
      if (tx_valid && tx_ready) begin
        if (expTx.size() == 0) begin
          nCmp++; nErr++;
          $display("FAIL unexpected_tx: got %h want none", tx_data);
        end else begin
          logic [7:0] t;
          t = expTx.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, t});
        end
      end
      if (cpu_reset) cpuResetCnt++;
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      nCmp++; nErr++;
      $display("FAIL rx_accept_timeout: got rx_ready 0 want 1");
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic waitTx(input string nm);
    int t;
    t = 0;
    while (expTx.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_tx_done"}, expTx.size(), 0);
  endtask

  task automatic runFrame(input vec_t v, input string nm);
    logic [7:0]  cs;
    logic [15:0] a16;
    logic [11:0] wa;
    int          rc0;
    cs  = 8'h00;
    a16 = v.addr;
    rc0 = cpuResetCnt;
    sendByte(8'hA5);
    chk({nm, "_stall_on"}, {31'd0, cpu_stall}, 1);
    sendByte(v.addr[15:8]); cs ^= v.addr[15:8];
    sendByte(v.addr[7:0]);  cs ^= v.addr[7:0];
    sendByte(v.cnt[15:8]);  cs ^= v.cnt[15:8];
    sendByte(v.cnt[7:0]);   cs ^= v.cnt[7:0];
    for (int w = 0; w < int'(v.cnt); w++) begin
      wa = a16[11:0] + 12'(w);
      expW.push_back({wa, v.words[w]});
      for (int k = 3; k >= 0; k--) begin
        sendByte(v.words[w][8*k +: 8]);
        cs ^= v.words[w][8*k +: 8];
      end
    end
    expTx.push_back(v.expAck ? 8'h06 : 8'h15);
    sendByte(v.badCs ? (cs ^ 8'h01) : cs);
    waitTx(nm);
    repeat (3) @(negedge clk);
    chk({nm, "_writes_left"}, expW.size(), 0);
    chk({nm, "_cpu_reset_pulses"}, cpuResetCnt - rc0, v.expAck ? 1 : 0);
    chk({nm, "_stall_off"}, {31'd0, cpu_stall}, 0);
    chk({nm, "_rx_ready_idle"}, {31'd0, rx_ready}, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] held;

    //            addr      cnt    words (w3..w0)                                   bad exp
    tbl[0] = '{16'h0010, 16'd2, {32'h0, 32'h0, 32'h01234567, 32'hDEADBEEF},       1'b0, 1'b1};
    tbl[1] = '{16'h0010, 16'd2, {32'h0, 32'h0, 32'h01234567, 32'hDEADBEEF},       1'b1, 1'b0};
    tbl[2] = '{16'h0FFF, 16'd2, {32'h0, 32'h0, 32'h55667788, 32'h11223344},       1'b0, 1'b1};
    tbl[3] = '{16'h0000, 16'd0, {32'h0, 32'h0, 32'h0, 32'h0},                     1'b0, 1'b1};
    tbl[4] = '{16'hF123, 16'd1, {32'h0, 32'h0, 32'h0, 32'hCAFEF00D},              1'b0, 1'b1};
    tbl[5] = '{16'h0200, 16'd4, {32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF, 32'h13579BDF}, 1'b1, 1'b0};

    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    #3;
    chk("rst_rx_ready",  {31'd0, rx_ready}, 1);
    chk("rst_tx_valid",  {31'd0, tx_valid}, 0);
    chk("rst_tx_data",   {24'd0, tx_data}, 0);
    chk("rst_imem_we",   {28'd0, imem_we}, 0);
    chk("rst_imem_addr", {20'd0, imem_addr}, 0);
    chk("rst_imem_din",  imem_din, 0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Bytes in IDLE other than START are dropped without stalling.
    sendByte(8'h55);
    sendByte(8'h00);
    @(negedge clk);
    chk("idle_drop_stall", {31'd0, cpu_stall}, 0);
    chk("idle_drop_rx_ready", {31'd0, rx_ready}, 1);
    runFrame(tbl[3], "t4_cnt0");

    for (int i = 0; i < 6; i++) runFrame(tbl[i], $sformatf("vec%0d", i));

    // Response backpressure: tx_data must hold and rx must be blocked.
    tx_ready = 1'b0;
    v = tbl[4];
    begin
      logic [7:0] cs;
      cs = 8'h00;
      sendByte(8'hA5);
      sendByte(8'h01); cs ^= 8'h01;
      sendByte(8'h00); cs ^= 8'h00;
      sendByte(8'h00); cs ^= 8'h00;
      sendByte(8'h01); cs ^= 8'h01;
      expW.push_back({12'h100, 32'h89ABCDEF});
      sendByte(8'h89); cs ^= 8'h89;
      sendByte(8'hAB); cs ^= 8'hAB;
      sendByte(8'hCD); cs ^= 8'hCD;
      sendByte(8'hEF); cs ^= 8'hEF;
      sendByte(cs);
    end
    @(negedge clk);
    held = tx_data;
    chk("t5_held_ack", {24'd0, held}, 32'h06);
    for (int c = 0; c < 10; c++) begin
      chk("t5_tx_valid", {31'd0, tx_valid}, 1);
      chk("t5_tx_stable", {24'd0, tx_data}, {24'd0, held});
      chk("t5_rx_blocked", {31'd0, rx_ready}, 0);
      @(negedge clk);
    end
    expTx.push_back(8'h06);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    waitTx("t5");
    repeat (3) @(negedge clk);
    chk("t5_stall_off", {31'd0, cpu_stall}, 0);
    chk("t5_writes_left", expW.size(), 0);

    // Asynchronous reset in the middle of a word.
    sendByte(8'hA5);
    sendByte(8'h00);
    sendByte(8'h10);
    sendByte(8'h00);
    sendByte(8'h02);
    sendByte(8'hDE);
    sendByte(8'hAD);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_stall", {31'd0, cpu_stall}, 0);
    chk("t6_rx_ready", {31'd0, rx_ready}, 1);
    chk("t6_imem_addr", {20'd0, imem_addr}, 0);
    chk("t6_imem_we", {28'd0, imem_we}, 0);
    chk("t6_tx_valid", {31'd0, tx_valid}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    runFrame(tbl[0], "t6_reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
